// File: rtl/btn_pkg.sv
// Shared definitions for board-input conditioning: debouncer state encoding and timing defaults.
package btn_pkg;

  localparam int unsigned CLK_HZ       = 125_000_000;
  localparam int unsigned DEBOUNCE_1MS = CLK_HZ / 1000;
  localparam int unsigned LONG_1S      = CLK_HZ;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous board input; reset loads a chosen idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic ff1;

  // Metastability chain; the raw pin feeds the first flop with no logic in front.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ff1 <= RESET_VAL;
      q   <= RESET_VAL;
    end else begin
      ff1 <= d;
      q   <= ff1;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronize, debounce, and emit level, edge pulses,
// a one-shot long-press pulse and a wrapping press counter.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_1MS,
  parameter int unsigned LONG_CYCLES     = LONG_1S,
  parameter bit          BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN,
  output logic       LEVEL,
  output logic       PRESS,
  output logic       RELEASE,
  output logic       LONG_PRESS,
  output logic [7:0] PRESS_COUNT
);

  localparam int unsigned CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES - 2);

  // Raw pin level that means "not pressed"; the synchronizer idles here.
  localparam logic RELEASED_RAW = ~BTN_ACTIVE_HIGH;

  btn_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold;
  logic              btn_q;
  logic              btn_s;

  sync_2ff #(
    .RESET_VAL (RELEASED_RAW)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (BTN),
    .q   (btn_q)
  );

  // Polarity fix after the synchronizer: btn_s is 1 when pressed.
  assign btn_s = BTN_ACTIVE_HIGH ? btn_q : ~btn_q;

  // Debounce FSM with registered level, pulses, hold timer and press counter.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hold        <= '0;
      LEVEL       <= 1'b0;
      PRESS       <= 1'b0;
      RELEASE     <= 1'b0;
      LONG_PRESS  <= 1'b0;
      PRESS_COUNT <= 8'd0;
    end else begin
      PRESS      <= 1'b0;
      RELEASE    <= 1'b0;
      LONG_PRESS <= 1'b0;

      case (state)
        S_IDLE: begin
          if (btn_s) begin
            state <= S_PRESS_WAIT;
            cnt   <= '0;
          end
        end

        S_PRESS_WAIT: begin
          if (!btn_s) begin
            state <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            state       <= S_PRESSED;
            PRESS       <= 1'b1;
            LEVEL       <= 1'b1;
            PRESS_COUNT <= PRESS_COUNT + 8'd1;
            hold        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_PRESSED: begin
          if (hold != HOLD_MAX) begin
            hold <= hold + HOLD_W'(1);
          end
          // Saturating hold counter passes this value once, so the pulse is one-shot.
          if (btn_s && (hold == HOLD_LONG)) begin
            LONG_PRESS <= 1'b1;
          end
          if (!btn_s) begin
            state <= S_RELEASE_WAIT;
            cnt   <= '0;
          end
        end

        S_RELEASE_WAIT: begin
          // Hold keeps running so a rejected release glitch does not delay LONG_PRESS.
          if (hold != HOLD_MAX) begin
            hold <= hold + HOLD_W'(1);
          end
          if (btn_s) begin
            state <= S_PRESSED;
          end else if (cnt == CNT_LAST) begin
            state   <= S_IDLE;
            RELEASE <= 1'b1;
            LEVEL   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing, all
// checked every cycle against a run-length reference model.
module tb_button_debouncer;

  localparam int unsigned D   = 4;
  localparam int unsigned L   = 20;
  localparam bit          ACT = 1'b1;

  localparam logic PR = ACT;   // raw pin level when pressed
  localparam logic RL = ~ACT;  // raw pin level when released

  logic       clk;
  logic       rst;
  logic       btn;
  logic       level;
  logic       press;
  logic       rel;
  logic       lp;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .BTN_ACTIVE_HIGH (ACT)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .BTN         (btn),
    .LEVEL       (level),
    .PRESS       (press),
    .RELEASE     (rel),
    .LONG_PRESS  (lp),
    .PRESS_COUNT (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the pin reaches the debouncer two edges late; a change is
  // accepted once D+1 consecutive samples disagree with the accepted level.
  // Long press fires L-1 edges after the press if the button is still down.
  logic [1:0] m_pipe;
  int         m_run;
  int         m_age;
  logic       m_s;
  logic       m_sprev;
  logic       m_level;
  logic       m_press;
  logic       m_rel;
  logic       m_long;
  logic [7:0] m_count;

  always @(posedge clk) begin
    if (!rst) begin
      m_pipe  = {RL, RL};
      m_run   = 0;
      m_age   = 0;
      m_sprev = 1'b0;
      m_level = 1'b0;
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_long  = 1'b0;
      m_count = 8'd0;
    end else begin
      m_s     = (m_pipe[1] == PR);
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_long  = 1'b0;
      if (m_age < 1000000) m_age = m_age + 1;
      if (m_level && m_s && m_sprev && (m_age == int'(L) - 1)) m_long = 1'b1;
      if (m_s != m_level) m_run = m_run + 1;
      else m_run = 0;
      if (m_run == int'(D) + 1) begin
        m_run = 0;
        if (!m_level) begin
          m_level = 1'b1;
          m_press = 1'b1;
          m_count = m_count + 8'd1;
          m_age   = 0;
        end else begin
          m_level = 1'b0;
          m_rel   = 1'b1;
        end
      end
      m_sprev = m_s;
      m_pipe  = {m_pipe[0], btn};
    end
  end

  task automatic reset_dut();
    rst = 1'b0;
    btn = RL;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      btn = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({level, press, rel, lp, count} !== 12'h000) begin
        errors++;
        $display("FAIL reset_zero cyc %0d: dut=%03h want=000", i, {level, press, rel, lp, count});
      end
    end
    rst = 1'b1;
    btn = RL;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({level, press, rel, lp, count} !== {m_level, m_press, m_rel, m_long, m_count}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: dut=%03h model=%03h", i,
                 {level, press, rel, lp, count}, {m_level, m_press, m_rel, m_long, m_count});
      end
    end
  endtask

  task automatic test_clean_press();
    int p_edge = -1;
    int np = 0;
    int nr = 0;
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      btn = PR;
      @(negedge clk);
      checks++;
      if ({level, press, rel, lp, count} !== {m_level, m_press, m_rel, m_long, m_count}) begin
        errors++;
        $display("FAIL clean_press cyc %0d: dut=%03h model=%03h", i,
                 {level, press, rel, lp, count}, {m_level, m_press, m_rel, m_long, m_count});
      end
      if (press === 1'b1) begin np++; p_edge = i + 1; end
      if (rel === 1'b1) nr++;
    end
    checks++;
    if (p_edge != 7 || np != 1 || nr != 0) begin
      errors++;
      $display("FAIL clean_press_edge: edge=%0d presses=%0d releases=%0d want 7/1/0", p_edge, np, nr);
    end
    checks++;
    if (level !== 1'b1 || count !== 8'd1) begin
      errors++;
      $display("FAIL clean_press_state: level=%b count=%0d want 1/1", level, count);
    end
  endtask

  task automatic test_bounce();
    int p_edge = -1;
    int np = 0;
    reset_dut();
    for (int i = 0; i < 37; i++) begin
      btn = (i < 25) ? (((i % 5) < 3) ? PR : RL) : PR;
      @(negedge clk);
      checks++;
      if ({level, press, rel, lp, count} !== {m_level, m_press, m_rel, m_long, m_count}) begin
        errors++;
        $display("FAIL bounce cyc %0d: dut=%03h model=%03h", i,
                 {level, press, rel, lp, count}, {m_level, m_press, m_rel, m_long, m_count});
      end
      if (press === 1'b1) begin np++; p_edge = i + 1; end
    end
    checks++;
    if (p_edge != 32 || np != 1 || count !== 8'd1) begin
      errors++;
      $display("FAIL bounce_press: edge=%0d presses=%0d count=%0d want 32/1/1", p_edge, np, count);
    end
  endtask

  task automatic test_long_press();
    int p_edge = -1;
    int l_edge = -1;
    int r_edge = -1;
    int nl = 0;
    reset_dut();
    for (int i = 0; i < 30; i++) begin
      btn = PR;
      @(negedge clk);
      checks++;
      if ({level, press, rel, lp, count} !== {m_level, m_press, m_rel, m_long, m_count}) begin
        errors++;
        $display("FAIL long_hold cyc %0d: dut=%03h model=%03h", i,
                 {level, press, rel, lp, count}, {m_level, m_press, m_rel, m_long, m_count});
      end
      if (press === 1'b1) p_edge = i + 1;
      if (lp === 1'b1) begin nl++; l_edge = i + 1; end
    end
    checks++;
    if (p_edge != 7 || l_edge != 26 || nl != 1) begin
      errors++;
      $display("FAIL long_timing: press=%0d long=%0d nlong=%0d want 7/26/1", p_edge, l_edge, nl);
    end
    for (int i = 0; i < 15; i++) begin
      btn = RL;
      @(negedge clk);
      checks++;
      if ({level, press, rel, lp, count} !== {m_level, m_press, m_rel, m_long, m_count}) begin
        errors++;
        $display("FAIL long_release cyc %0d: dut=%03h model=%03h", i,
                 {level, press, rel, lp, count}, {m_level, m_press, m_rel, m_long, m_count});
      end
      if (rel === 1'b1) r_edge = i + 1;
      if (lp === 1'b1) nl++;
    end
    checks++;
    if (r_edge != 7 || nl != 1 || level !== 1'b0) begin
      errors++;
      $display("FAIL long_release_end: rel=%0d nlong=%0d level=%b want 7/1/0", r_edge, nl, level);
    end
  endtask

  task automatic test_release_glitch();
    int p_edge = -1;
    int l_edge = -1;
    int nr = 0;
    int lvl_bad = 0;
    reset_dut();
    for (int i = 0; i < 30; i++) begin
      btn = (i == 10 || i == 11) ? RL : PR;
      @(negedge clk);
      checks++;
      if ({level, press, rel, lp, count} !== {m_level, m_press, m_rel, m_long, m_count}) begin
        errors++;
        $display("FAIL glitch cyc %0d: dut=%03h model=%03h", i,
                 {level, press, rel, lp, count}, {m_level, m_press, m_rel, m_long, m_count});
      end
      if (press === 1'b1) p_edge = i + 1;
      if (lp === 1'b1) l_edge = i + 1;
      if (rel === 1'b1) nr++;
      if (i + 1 >= 7 && level !== 1'b1) lvl_bad++;
    end
    checks++;
    if (p_edge != 7 || l_edge != 26 || nr != 0 || lvl_bad != 0) begin
      errors++;
      $display("FAIL glitch_result: press=%0d long=%0d releases=%0d level_drops=%0d want 7/26/0/0",
               p_edge, l_edge, nr, lvl_bad);
    end
  endtask

  task automatic test_wrap();
    int np = 0;
    reset_dut();
    for (int r = 0; r < 256; r++) begin
      for (int i = 0; i < 16; i++) begin
        btn = (i < 8) ? PR : RL;
        @(negedge clk);
        checks++;
        if ({level, press, rel, lp, count} !== {m_level, m_press, m_rel, m_long, m_count}) begin
          errors++;
          $display("FAIL wrap r%0d cyc %0d: dut=%03h model=%03h", r, i,
                   {level, press, rel, lp, count}, {m_level, m_press, m_rel, m_long, m_count});
        end
        if (press === 1'b1) np++;
      end
    end
    checks++;
    if (count !== 8'd0 || np != 256) begin
      errors++;
      $display("FAIL wrap_256: count=%0d presses=%0d want 0/256", count, np);
    end
    for (int i = 0; i < 8; i++) begin
      btn = PR;
      @(negedge clk);
    end
    checks++;
    if (count !== 8'd1 || level !== 1'b1) begin
      errors++;
      $display("FAIL wrap_257: count=%0d level=%b want 1/1", count, level);
    end
  endtask

  task automatic test_reset_mid_press();
    int p_edge = -1;
    reset_dut();
    // One full press/release first so reset has a nonzero count to clear.
    for (int i = 0; i < 16; i++) begin
      btn = (i < 8) ? PR : RL;
      @(negedge clk);
    end
    checks++;
    if (count !== 8'd1) begin
      errors++;
      $display("FAIL midreset_pre: count=%0d want 1", count);
    end
    for (int i = 0; i < 4; i++) begin
      btn = PR;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({level, press, rel, lp, count} !== 12'h000) begin
      errors++;
      $display("FAIL midreset_zero: dut=%03h want=000", {level, press, rel, lp, count});
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      btn = PR;
      @(negedge clk);
      checks++;
      if ({level, press, rel, lp, count} !== {m_level, m_press, m_rel, m_long, m_count}) begin
        errors++;
        $display("FAIL midreset cyc %0d: dut=%03h model=%03h", i,
                 {level, press, rel, lp, count}, {m_level, m_press, m_rel, m_long, m_count});
      end
      if (press === 1'b1) p_edge = i + 1;
    end
    checks++;
    if (p_edge != 7 || count !== 8'd1) begin
      errors++;
      $display("FAIL midreset_press: edge=%0d count=%0d want 7/1", p_edge, count);
    end
  endtask

  task automatic test_random();
    logic cur = RL;
    int   left = 0;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        cur  = ~cur;
        left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 8));
      end
      left--;
      btn = cur;
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if ({level, press, rel, lp, count} !== {m_level, m_press, m_rel, m_long, m_count}) begin
        errors++;
        $display("FAIL random cyc %0d: dut=%03h model=%03h", i,
                 {level, press, rel, lp, count}, {m_level, m_press, m_rel, m_long, m_count});
      end
      checks++;
      if ((int'(press) + int'(rel) + int'(lp)) > 1) begin
        errors++;
        $display("FAIL random_overlap cyc %0d: press=%b rel=%b long=%b want at most one", i, press, rel, lp);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    btn = RL;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_glitch();
    test_wrap();
    test_reset_mid_press();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side counterpart to the LED drivers: takes a raw, bouncing push-button or switch pin into the CLK domain (nominal 125 MHz).
- Debounces it and produces a clean level, single-cycle press/release/long-press pulses and a wrapping press counter.
- Sits between board pins and control logic; LED blink blocks consume its outputs.

Parameters:
- DEBOUNCE_CYCLES, 125000, cycles the synchronized input must stay stable before a change is accepted (1 ms at 125 MHz); legal range ≥2.
- LONG_CYCLES, 125000000, cycles in accepted-pressed state before LONG_PRESS fires (1 s); must be greater than DEBOUNCE_CYCLES.
- BTN_ACTIVE_HIGH, 1, 1: pin high = pressed; 0: pin low = pressed (the input is inverted after the synchronizer).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-low reset.
- BTN  input  1  raw asynchronous button pin.
- LEVEL  output  1  debounced state, 1 = pressed.
- PRESS  output  1  one-cycle pulse on accepted press.
- RELEASE  output  1  one-cycle pulse on accepted release.
- LONG_PRESS  output  1  one-cycle pulse, at most once per press.
- PRESS_COUNT  output  8  number of accepted presses, modulo 256.

Behaviour:
- Reset (RST==0 at a rising edge):
  - State goes to IDLE; all counters are 0.
  - Both synchronizer flops load the released level.
  - LEVEL, PRESS, RELEASE, LONG_PRESS and PRESS_COUNT are all 0.
  - Reset overrides everything, including a press in progress or a pending pulse.
- Synchronizer: 2-flop chain, then polarity fix; the result is btn_s (1 = pressed). No logic is applied to BTN before the first flop.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Debounce counter cnt is $clog2(DEBOUNCE_CYCLES) bits wide.
- IDLE:
  - btn_s==1 → PRESS_WAIT with cnt<=0.
- PRESS_WAIT:
  - btn_s==0 → IDLE (bounce rejected; no pulse).
  - btn_s==1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED; in the same edge, PRESS<=1, LEVEL<=1, PRESS_COUNT<=PRESS_COUNT+1 (255 wraps to 0), hold<=0.
  - Otherwise cnt<=cnt+1.
- PRESSED:
  - hold counter ($clog2(LONG_CYCLES) bits) increments each cycle and saturates at LONG_CYCLES-1.
  - When hold==LONG_CYCLES-2 and btn_s==1, LONG_PRESS<=1 (fires exactly once per press).
  - btn_s==0 → RELEASE_WAIT with cnt<=0. The hold counter keeps counting in RELEASE_WAIT.
- RELEASE_WAIT:
  - btn_s==1 → PRESSED (glitch rejected; hold is NOT reset; no pulse).
  - btn_s==0 and cnt==DEBOUNCE_CYCLES-1 → IDLE; RELEASE<=1, LEVEL<=0.
  - Otherwise cnt<=cnt+1.
- Pulses:
  - PRESS, RELEASE and LONG_PRESS are registered and default to 0 every cycle; each is high for exactly one cycle.
  - They are never simultaneous by construction: LONG_PRESS fires only in PRESSED, so LONG_CYCLES > DEBOUNCE_CYCLES guarantees it comes after PRESS.
- Latency:
  - First edge sampling BTN pressed = edge 1 (ff1), then edge 2 (ff2), then edge 3 (enter PRESS_WAIT, cnt=0).
  - PRESS is registered at edge DEBOUNCE_CYCLES+3, provided BTN stays pressed throughout. RELEASE latency is symmetric.
- LONG_PRESS timing: registered exactly LONG_CYCLES-1 edges after the PRESS edge, if held continuously.
- Held through reset: after RST deasserts, the synchronizer refills with pressed and a full debounce runs, so PRESS fires at DEBOUNCE_CYCLES+3 edges after the first non-reset edge.
- LEVEL changes only on the PRESS and RELEASE edges, never elsewhere.

Decomposition:
- Shared package/include btn_pkg:
  - FSM state encoding (2-bit localparams S_IDLE=0, S_PRESS_WAIT=1, S_PRESSED=2, S_RELEASE_WAIT=3).
  - Default timing constants CLK_HZ=125000000, DEBOUNCE_1MS, LONG_1S.
- One sub-module: sync_2ff (2-flop synchronizer with reset value parameter), reusable for other board inputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, BTN_ACTIVE_HIGH=1):
- Clean press: BTN 0→1 held → PRESS high one cycle at edge 7, LEVEL=1, PRESS_COUNT=1, no RELEASE.
- Bounce: BTN pulses 1 for 3 cycles, 0 for 2, repeated 5×, then held 1 → no PRESS until 4 stable cycles; exactly one PRESS, PRESS_COUNT=1.
- Long press and release: hold 30 cycles → LONG_PRESS once, 19 edges after PRESS; release → RELEASE at edge 7 after release, LEVEL=0, LONG_PRESS never repeats.
- Release glitch: while PRESSED, BTN=0 for 2 cycles then 1 → no RELEASE, LEVEL stays 1, LONG_PRESS still at its original edge.
- Wrap: 256 clean press/release cycles → PRESS_COUNT returns to 0; 257th press gives 1.
- Reset mid-press: RST=0 during PRESS_WAIT with BTN held → all outputs 0 next edge; RST=1 with BTN still 1 → PRESS at edge 7 after reset release, PRESS_COUNT=1.
